// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between NUM_REQ requesters.
// Grants at most one request per cycle. A read's requester id travels down a
// READ_LATENCY-deep tag pipeline so the data can be routed back to it.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration from a rotating priority pointer
//   undefined -> fixed priority, lowest requester index wins
module mem_port_arbiter #(
  parameter int          NUM_REQ      = 3,
  parameter int          READ_LATENCY = 2,
  parameter logic [31:0] MMIO_ADDR_1  = 32'h0000_0FFF,
  parameter logic [31:0] MMIO_ADDR_2  = 32'h0000_1000,
  localparam int         IDW          = $clog2(NUM_REQ)
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ-1:0]     req_we,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic [IDW-1:0]         grant_id,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_din,
  output logic                   mem_en,
  output logic                   mem_we,
  input  logic [31:0]            mem_dout
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("mem_port_arbiter: NUM_REQ must be 2..8");
  end
  if (READ_LATENCY < 1) begin : g_bad_latency
    $error("mem_port_arbiter: READ_LATENCY must be at least 1");
  end

  localparam int LAST = READ_LATENCY - 1;

  // Per-stage read tag; the valid bit lives in its own shift register.
  typedef struct packed {
    logic [IDW-1:0] id;
    logic           is_mmio;
    logic [31:0]    mmio_data;
  } tag_t;

  logic [NUM_REQ-1:0][31:0] addr_a;
  logic [NUM_REQ-1:0][31:0] wdata_a;

  assign addr_a  = req_addr;
  assign wdata_a = req_wdata;

  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0] rot;
  logic [IDW-1:0]     off;
  logic [IDW:0]       sum;

  // Rotate requests so the pointer sits at bit 0, take the lowest set bit,
  // then add the pointer back (mod NUM_REQ) to recover the requester index.
  always_comb begin
    rot     = NUM_REQ'({req_valid, req_valid} >> ptr_q);
    gnt_any = 1'b0;
    off     = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (rot[k]) begin
        gnt_any = 1'b1;
        off     = IDW'(k);
      end
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
    gnt_idx = sum[IDW-1:0];
    if (rst) gnt_any = 1'b0;
  end

  // Pointer moves just past the winner after a transfer, holds otherwise.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      if (gnt_idx == IDW'(NUM_REQ-1)) ptr_d = '0;
      else                            ptr_d = gnt_idx + 1'b1;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clock) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  // Fixed priority: lowest valid index wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (req_valid[k]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(k);
      end
    end
    if (rst) gnt_any = 1'b0;
  end
`endif

  logic rd_issue;
  logic issue_mmio;

  // Drive the memory port from the winner; everything is zero when idle.
  always_comb begin
    req_ready = '0;
    grant_id  = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    rd_issue  = 1'b0;
    if (gnt_any) begin
      req_ready = NUM_REQ'(1) << gnt_idx;
      grant_id  = gnt_idx;
      mem_en    = 1'b1;
      mem_we    = req_we[gnt_idx];
      mem_addr  = addr_a[gnt_idx];
      mem_din   = wdata_a[gnt_idx];
      rd_issue  = ~req_we[gnt_idx];
    end
    issue_mmio = (mem_addr == MMIO_ADDR_1) || (mem_addr == MMIO_ADDR_2);
  end

  logic [READ_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  tag_t [READ_LATENCY-1:0] tag_q, tag_d;

  // Tag pipeline shift. MMIO data comes back combinationally in the issue
  // cycle, so it is captured here and replayed at the normal read latency.
  always_comb begin
    vld_pipe_d    = '0;
    tag_d         = tag_q;
    vld_pipe_d[0] = rd_issue;
    tag_d[0].id        = gnt_idx;
    tag_d[0].is_mmio   = issue_mmio;
    tag_d[0].mmio_data = issue_mmio ? mem_dout : '0;
    for (int s = 1; s < READ_LATENCY; s++) begin
      vld_pipe_d[s] = vld_pipe_q[s-1];
      tag_d[s]      = tag_q[s-1];
    end
  end

  // Valid bits are reset so a reset drops every in-flight read.
  always_ff @(posedge clock) begin
    if (rst) vld_pipe_q <= '0;
    else     vld_pipe_q <= vld_pipe_d;
  end

  // Tag payload needs no reset; it is qualified by the valid bits.
  always_ff @(posedge clock) begin
    tag_q <= tag_d;
  end

  // Final stage routes data to the originating requester; suppressed in reset.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (vld_pipe_q[LAST] && !rst) begin
      rsp_valid = NUM_REQ'(1) << tag_q[LAST].id;
      rsp_rdata = tag_q[LAST].is_mmio ? tag_q[LAST].mmio_data : mem_dout;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model on the port, reference model of
// arbitration and memory contents, response scoreboard with a separate monitor.
module tb_mem_port_arbiter;
  localparam int N = 3;
  localparam int L = 2;
  localparam int IDW = 2;
  localparam logic [31:0] MM1 = 32'h0000_0FFF;
  localparam logic [31:0] MM2 = 32'h0000_1000;

  logic clock = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready, req_we, rsp_valid;
  logic [N*32-1:0] req_addr, req_wdata;
  logic [31:0] rsp_rdata, mem_addr, mem_din, mem_dout;
  logic [IDW-1:0] grant_id;
  logic mem_en, mem_we;

  always #5 clock = ~clock;

  mem_port_arbiter #(.NUM_REQ(N), .READ_LATENCY(L), .MMIO_ADDR_1(MM1), .MMIO_ADDR_2(MM2)) dut (
    .clock(clock), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .grant_id(grant_id),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_en(mem_en), .mem_we(mem_we),
    .mem_dout(mem_dout));

  function automatic logic is_mmio(logic [31:0] a);
    return (a == MM1) || (a == MM2);
  endfunction

  function automatic logic [31:0] init_val(int i);
    if (i == 32'h10) return 32'hDEADBEEF;
    return 32'h5A00_0000 ^ (i * 32'h0000_9E37);
  endfunction

  // memory port model: array reads take L cycles, MMIO reads are combinational
  logic [31:0] arr [8192];
  logic [31:0] mmio_q;
  logic [31:0] rd1, rd2;
  initial begin
    for (int i = 0; i < 8192; i++) arr[i] = init_val(i);
    mmio_q = 32'h0;
    rd1 = 32'h0;
    rd2 = 32'h0;
  end
  always @(posedge clock) begin
    if (mem_en && mem_we) begin
      if (is_mmio(mem_addr)) mmio_q <= mem_din;
      else arr[mem_addr[12:0]] <= mem_din;
    end
    rd1 <= (mem_en && !mem_we && !is_mmio(mem_addr)) ? arr[mem_addr[12:0]] : 32'hBAD0_BAD0;
    rd2 <= rd1;
  end
  assign mem_dout = (mem_en && !mem_we && is_mmio(mem_addr)) ? mmio_q : rd2;

  // reference model state
  logic [31:0] ref_mem [8192];
  logic [31:0] ref_mmio;
  int ref_ptr;
  initial begin
    for (int i = 0; i < 8192; i++) ref_mem[i] = init_val(i);
    ref_mmio = 32'h0;
    ref_ptr = 0;
  end

  typedef struct {
    int id;
    logic [31:0] data;
    int due;
  } exp_t;
  exp_t sb[$];

  int cyc = 0;
  int nchk = 0;
  int nerr = 0;
  logic [N-1:0] last_rdy;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // first valid requester scanning upward from p with wrap-around
  function automatic int pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // one clock: check the issue side at negedge, advance, retire transfers
  task automatic step();
    int g;
    logic [N-1:0] done;
    exp_t e;
    logic [31:0] a;
    done = '0;
    @(negedge clock);
    last_rdy = req_ready;
    if (rst) begin
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_mem_en", 32'(mem_en), 32'h0);
      sb.delete();
      ref_ptr = 0;
    end else begin
      g = pick(req_valid, ref_ptr);
      if (g < 0) begin
        chk("idle_ready", 32'(req_ready), 32'h0);
        chk("idle_grant_id", 32'(grant_id), 32'h0);
        chk("idle_mem_en", 32'(mem_en), 32'h0);
        chk("idle_mem_we", 32'(mem_we), 32'h0);
        chk("idle_mem_addr", mem_addr, 32'h0);
        chk("idle_mem_din", mem_din, 32'h0);
      end else begin
        a = req_addr[g*32 +: 32];
        chk("ready", 32'(req_ready), 32'(1) << g);
        chk("grant_id", 32'(grant_id), 32'(g));
        chk("mem_en", 32'(mem_en), 32'h1);
        chk("mem_we", 32'(mem_we), 32'(req_we[g]));
        chk("mem_addr", mem_addr, a);
        chk("mem_din", mem_din, req_wdata[g*32 +: 32]);
        done[g] = 1'b1;
        if (req_we[g]) begin
          if (is_mmio(a)) ref_mmio = req_wdata[g*32 +: 32];
          else ref_mem[a[12:0]] = req_wdata[g*32 +: 32];
        end else begin
          e.id = g;
          e.data = is_mmio(a) ? ref_mmio : ref_mem[a[12:0]];
          e.due = cyc + L;
          sb.push_back(e);
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        ref_ptr = (g + 1) % N;
`endif
      end
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) if (done[i]) req_valid[i] = 1'b0;
  endtask

  task automatic arm(int i, logic we, logic [31:0] a, logic [31:0] d);
    req_valid[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*32 +: 32] = a;
    req_wdata[i*32 +: 32] = d;
  endtask

  task automatic quiesce(int n);
    req_valid = '0;
    for (int k = 0; k < n; k++) step();
  endtask

  // response monitor: pops the scoreboard whenever the DUT presents a response
  always @(negedge clock) begin
    exp_t e;
    if (rst) begin
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    end else if (rsp_valid != '0) begin
      if (sb.size() == 0) begin
        chk("spurious_rsp", 32'(rsp_valid), 32'h0);
      end else begin
        e = sb.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
        chk("rsp_rdata", rsp_rdata, e.data);
        chk("rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end else begin
      chk("idle_rsp_rdata", rsp_rdata, 32'h0);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("missing_rsp", 32'(rsp_valid), 32'(1) << e.id);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int gcnt [N];
    int a;
    rst = 1'b1;
    req_valid = '0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    last_rdy = '0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_grant_id", 32'(grant_id), 32'h0);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);

    // contention: everyone keeps reading distinct addresses
    for (int i = 0; i < N; i++) gcnt[i] = 0;
    a = 32'h20;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) if (!req_valid[i]) begin arm(i, 1'b0, 32'(a), $urandom); a++; end
      step();
      for (int i = 0; i < N; i++) if (last_rdy[i]) gcnt[i]++;
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < N; i++) chk("rr_fair_count", 32'(gcnt[i]), 32'd2);
`else
    chk("fixed_req0_count", 32'(gcnt[0]), 32'd6);
`endif
    quiesce(4);

    // single read
    arm(1, 1'b0, 32'h10, 32'h0);
    step();
    chk("single_read_ready", 32'(last_rdy), 32'b010);
    quiesce(4);

    // MMIO write then read, consecutive cycles
    arm(2, 1'b1, MM2, 32'h12345678);
    step();
    arm(2, 1'b0, MM1, 32'h0);
    step();
    quiesce(4);

    // write then read of the same array word from a different requester
    arm(0, 1'b1, 32'h200, 32'hA5A5A5A5);
    step();
    arm(1, 1'b0, 32'h200, 32'h0);
    step();
    quiesce(4);

    // reset with reads in flight
    arm(0, 1'b0, 32'h30, 32'h0);
    step();
    rst = 1'b1;
    arm(1, 1'b0, 32'h31, 32'h0);
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) if (!req_valid[i]) arm(i, 1'b0, 32'(32'h40 + i), 32'h0);
    step();
    chk("post_rst_first_grant", 32'(last_rdy), 32'b001);
    for (int k = 0; k < 6 && req_valid != '0; k++) step();
    chk("post_rst_drained", 32'(req_valid), 32'h0);
    quiesce(4);

    // random traffic with occasional reset
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 9) < 6)
          arm(i, ($urandom_range(0, 2) == 0), 32'($urandom_range(0, 63)), $urandom);
      if ($urandom_range(0, 149) == 0) rst = 1'b1;
      step();
      rst = 1'b0;
    end
    quiesce(L + 3);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
